sa_os_array: RTL and testbench

Parametrised output-stationary systolic matrix multiplier. It computes C = A x B, where A is N x K and B is K x N, with K selectable at run time.
- Input skewing is built in.
- A start/done control FSM sequences each job.
- A valid/ready beat handshake feeds the operands.
- Accumulator width is configurable.
- It sits between the operand buffers and the result collector, and is the next generation of the fixed 8x8 enable-driven PE array.

---
 rtl/sa_os_array.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_sa_os_array.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_os_array.sv
// sa_os_array: output-stationary N x N systolic matrix multiplier, C = A x B.
//
// A is N x K and B is K x N; K is taken from k_len when a job starts.
// One operand beat (column k of A, row k of B) is accepted per valid/ready
// handshake. Row i of A and column j of B are skewed on entry so that pair k
// meets in PE(i,j) exactly i+j cycles after it was injected. Each PE keeps its
// own accumulator, which drives c_flat directly.
//
// Optional build macro: SA_SAT_EN
//   defined   - accumulators saturate at 2^AW-1, sticky ovf flag
//   undefined - accumulators wrap modulo 2^AW, ovf tied low
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        job request, sampled in IDLE only
//   k_len        inner dimension K, latched with an accepted start
//   in_valid     operand beat valid
//   in_ready     operand beat accepted when in_valid & in_ready (LOAD only)
//   a_vec        column k of A, row i at a_vec[i*DW +: DW]
//   b_vec        row k of B, column j at b_vec[j*DW +: DW]
//   busy         job in progress (state != IDLE)
//   done         one-cycle pulse, c_flat valid from this cycle
//   c_flat       C[i][j] at c_flat[(i*N+j)*AW +: AW]
//   ovf          sticky saturation flag (SA_SAT_EN builds only)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; c_flat holds the previous result
// LOAD   | accepting operand beats until k_len beats have been taken
// FLUSH  | 2N-1 cycles of zero injection to drain the skewed wavefront
// DONE   | one-cycle done pulse, result stable

module sa_os_array #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 24,
    parameter int KW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KW-1:0]       k_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DW-1:0]     a_vec,
    input  logic [N*DW-1:0]     b_vec,
    output logic                busy,
    output logic                done,
    output logic [N*N*AW-1:0]   c_flat,
    output logic                ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Flush down-counter is loaded with 2N-2 and exits on zero: 2N-1 cycles.
    localparam int            FW         = $clog2(2*N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2*N-2);

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   cnt_q;
    logic [FW-1:0]   fcnt_q;

    logic            start_acc;
    logic            beat_acc;
    logic            last_beat;
    logic            flush_end;
    logic            acc_en;

    logic [N*DW-1:0] inj_a;
    logic [N*DW-1:0] inj_b;

    // Operand fabric: a flows east along rows, b flows south along columns.
    logic [DW-1:0]   a_in [N][N];
    logic [DW-1:0]   b_in [N][N];

    assign start_acc = (state_q == S_IDLE) && start;
    assign beat_acc  = (state_q == S_LOAD) && in_valid;
    assign last_beat = beat_acc && (cnt_q == k_q - KW'(1));
    assign flush_end = (state_q == S_FLUSH) && (fcnt_q == '0);
    assign acc_en    = (state_q == S_LOAD) || (state_q == S_FLUSH);

    // Bubbles and the flush phase feed zeros, which accumulate harmlessly.
    assign inj_a = beat_acc ? a_vec : '0;
    assign inj_b = beat_acc ? b_vec : '0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (k_len == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_beat) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (flush_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            S_IDLE:  busy     = 1'b0;
            S_LOAD:  in_ready = 1'b1;
            S_FLUSH: in_ready = 1'b0;
            S_DONE:  done     = 1'b1;
            default: busy     = 1'b0;
        endcase
    end

    // Beat counter, latched K and flush timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q    <= '0;
            cnt_q  <= '0;
            fcnt_q <= '0;
        end else begin
            if (start_acc) begin
                k_q   <= k_len;
                cnt_q <= '0;
            end else if (beat_acc) begin
                cnt_q <= cnt_q + KW'(1);
            end

            if (last_beat) begin
                fcnt_q <= FLUSH_LAST;
            end else if ((state_q == S_FLUSH) && (fcnt_q != '0)) begin
                fcnt_q <= fcnt_q - FW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Input skew: row i of A delayed i cycles, column j of B delayed j.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N; gi++) begin : g_row_skew
        if (gi == 0) begin : g_nodly
            assign a_in[0][0] = inj_a[DW-1:0];
        end else begin : g_dly
            logic [DW-1:0] sr_q [gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < gi; d++) begin
                        sr_q[d] <= '0;
                    end
                end else begin
                    sr_q[0] <= inj_a[gi*DW +: DW];
                    for (int d = 1; d < gi; d++) begin
                        sr_q[d] <= sr_q[d-1];
                    end
                end
            end

            assign a_in[gi][0] = sr_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < N; gj++) begin : g_col_skew
        if (gj == 0) begin : g_nodly
            assign b_in[0][0] = inj_b[DW-1:0];
        end else begin : g_dly
            logic [DW-1:0] sr_q [gj];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int d = 0; d < gj; d++) begin
                        sr_q[d] <= '0;
                    end
                end else begin
                    sr_q[0] <= inj_b[gj*DW +: DW];
                    for (int d = 1; d < gj; d++) begin
                        sr_q[d] <= sr_q[d-1];
                    end
                end
            end

            assign b_in[0][gj] = sr_q[gj-1];
        end
    end

    // ------------------------------------------------------------------
    // PE grid
    // ------------------------------------------------------------------
`ifdef SA_SAT_EN
    logic [N*N-1:0] sat_hit;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_pe_row
        for (genvar gj = 0; gj < N; gj++) begin : g_pe
            logic [2*DW-1:0] prod;
            logic [AW-1:0]   acc_q;
            logic [AW-1:0]   acc_d;

            assign prod = {{DW{1'b0}}, a_in[gi][gj]} * {{DW{1'b0}}, b_in[gi][gj]};

`ifdef SA_SAT_EN
            logic [AW:0] sum;
            assign sum   = {1'b0, acc_q} + (AW+1)'(prod);
            assign acc_d = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
            assign sat_hit[gi*N+gj] = acc_en && sum[AW];
`else
            assign acc_d = acc_q + AW'(prod);
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_q <= '0;
                end else if (start_acc) begin
                    acc_q <= '0;
                end else if (acc_en) begin
                    acc_q <= acc_d;
                end
            end

            assign c_flat[(gi*N+gj)*AW +: AW] = acc_q;

            // The last column and last row have no neighbour to feed.
            if (gj < N-1) begin : g_east
                logic [DW-1:0] a_q;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_q <= '0;
                    end else begin
                        a_q <= a_in[gi][gj];
                    end
                end
                assign a_in[gi][gj+1] = a_q;
            end

            if (gi < N-1) begin : g_south
                logic [DW-1:0] b_q;
                always_ff @(posedge clk) begin
                    if (rst) begin
                        b_q <= '0;
                    end else begin
                        b_q <= b_in[gi][gj];
                    end
                end
                assign b_in[gi+1][gj] = b_q;
            end
        end
    end

`ifdef SA_SAT_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (start_acc) begin
            ovf_q <= 1'b0;
        end else if (|sat_hit) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_sa_os_array.sv
`timescale 1ns/1ps

module tb_sa_os_array;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int AW     = 24;
    localparam int AW2    = 16;
    localparam int KW     = 16;
    localparam int KMAX   = 16;
    localparam int BUDGET = 200;

    logic                 clk = 1'b0;
    logic                 rst;

    logic                 start;
    logic [KW-1:0]        k_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [N*DW-1:0]      a_vec;
    logic [N*DW-1:0]      b_vec;
    logic                 busy;
    logic                 done;
    logic [N*N*AW-1:0]    c_flat;
    logic                 ovf;

    logic                 start2;
    logic [KW-1:0]        k_len2;
    logic                 in_valid2;
    logic                 in_ready2;
    logic [N*DW-1:0]      a_vec2;
    logic [N*DW-1:0]      b_vec2;
    logic                 busy2;
    logic                 done2;
    logic [N*N*AW2-1:0]   c_flat2;
    logic                 ovf2;

    sa_os_array #(.N(N), .DW(DW), .AW(AW), .KW(KW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_vec    (a_vec),
        .b_vec    (b_vec),
        .busy     (busy),
        .done     (done),
        .c_flat   (c_flat),
        .ovf      (ovf)
    );

    sa_os_array #(.N(N), .DW(DW), .AW(AW2), .KW(KW)) dut16 (
        .clk      (clk),
        .rst      (rst),
        .start    (start2),
        .k_len    (k_len2),
        .in_valid (in_valid2),
        .in_ready (in_ready2),
        .a_vec    (a_vec2),
        .b_vec    (b_vec2),
        .busy     (busy2),
        .done     (done2),
        .c_flat   (c_flat2),
        .ovf      (ovf2)
    );

    always #5 clk = ~clk;

    // a_mode: 0 identity, 1 all 255, else random
    // b_mode: 0 B[k][j]=4k+j+1, 1 all 255, else random
    // exp_kind: 0 golden model, 1 C[i][j]=4i+j+1, 2 every element = exp_val
    typedef struct {
        int          k;
        int          a_mode;
        int          b_mode;
        logic [31:0] bubbles;
        bit          poke_start;
        int          exp_kind;
        int          exp_val;
    } job_t;

    int checks = 0;
    int errors = 0;

    int am [N][KMAX];
    int bm [KMAX][N];
    longint cm [N][N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] cval(input int i, input int j);
        return c_flat[(i*N+j)*AW +: AW];
    endfunction

    function automatic logic [AW2-1:0] cval2(input int i, input int j);
        return c_flat2[(i*N+j)*AW2 +: AW2];
    endfunction

    task automatic fill(input job_t j);
        longint s;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < KMAX; k++) begin
                case (j.a_mode)
                    0:       am[i][k] = (i == k) ? 1 : 0;
                    1:       am[i][k] = 255;
                    default: am[i][k] = int'($urandom_range(0, 255));
                endcase
            end
        end
        for (int k = 0; k < KMAX; k++) begin
            for (int c = 0; c < N; c++) begin
                case (j.b_mode)
                    0:       bm[k][c] = 4*k + c + 1;
                    1:       bm[k][c] = 255;
                    default: bm[k][c] = int'($urandom_range(0, 255));
                endcase
            end
        end
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int k = 0; k < j.k; k++) begin
                    s += longint'(am[i][k]) * longint'(bm[k][c]);
                end
                cm[i][c] = s & ((64'd1 << AW) - 1);
            end
        end
    endtask

    task automatic check_c(input string tag, input job_t j);
        longint e;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                case (j.exp_kind)
                    0:       e = cm[i][c];
                    1:       e = 4*i + c + 1;
                    default: e = j.exp_val;
                endcase
                chk($sformatf("%s_c%0d%0d", tag, i, c), 64'(cval(i, c)), e);
            end
        end
    endtask

    task automatic drive_beat(input int k);
        for (int i = 0; i < N; i++) begin
            a_vec[i*DW +: DW] = DW'(am[i][k]);
            b_vec[i*DW +: DW] = DW'(bm[k][i]);
        end
    endtask

    task automatic run_job(input string tag, input job_t j);
        int beat;
        int cyc;
        int n;
        int extra;
        fill(j);
        start = 1'b1;
        k_len = KW'(j.k);
        tick();
        start = 1'b0;
        if (j.k == 0) begin
            // IDLE goes straight to DONE: done in the cycle after the start edge
            chk({tag, "_k0_done"}, 64'(done), 1);
            chk({tag, "_k0_busy"}, 64'(busy), 1);
            check_c(tag, j);
            tick();
            chk({tag, "_k0_done_low"}, 64'(done), 0);
            chk({tag, "_k0_idle"}, 64'(busy), 0);
            return;
        end
        beat = 0;
        cyc  = 0;
        while (beat < j.k && cyc < BUDGET) begin
            chk({tag, "_load_ready"}, 64'(in_ready), 1);
            if (j.bubbles[cyc % 32]) begin
                in_valid = 1'b0;
                a_vec    = '1;
                b_vec    = '1;
            end else begin
                in_valid = 1'b1;
                drive_beat(beat);
            end
            start = j.poke_start && (cyc == 1);
            tick();
            if (in_valid) beat++;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        if (beat != j.k) chk({tag, "_load_timeout"}, 64'(beat), 64'(j.k));
        // Now just after the edge that took the last beat.
        n = 0;
        while (!done && n < BUDGET) begin
            chk({tag, "_flush_ready"}, 64'(in_ready), 0);
            start = j.poke_start && (n == 2);
            tick();
            n++;
        end
        start = 1'b0;
        // done visible in the 2N-th cycle after the last-beat edge
        chk({tag, "_done_latency"}, 64'(n), 64'(2*N-1));
        check_c(tag, j);
        chk({tag, "_ovf"}, 64'(ovf), 0);
        tick();
        chk({tag, "_done_pulse"}, 64'(done), 0);
        chk({tag, "_busy_after"}, 64'(busy), 0);
        extra = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (done) extra++;
        end
        chk({tag, "_extra_done"}, 64'(extra), 0);
        check_c({tag, "_hold"}, j);
    endtask

    job_t jobs [6];
    job_t rj;

    initial begin
        int n;
        int extra;
        longint e2;

        rst       = 1'b1;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_vec     = '0;
        b_vec     = '0;
        start2    = 1'b0;
        k_len2    = '0;
        in_valid2 = 1'b0;
        a_vec2    = '0;
        b_vec2    = '0;

        jobs[0] = '{4, 0, 0, 32'h0000_0000, 1'b0, 1, 0};
        jobs[1] = '{4, 1, 1, 32'h0000_0000, 1'b0, 2, 260100};
        jobs[2] = '{7, 2, 2, 32'h5249_2A49, 1'b0, 0, 0};
        jobs[3] = '{0, 2, 2, 32'h0000_0000, 1'b0, 2, 0};
        jobs[4] = '{5, 2, 0, 32'h0000_0006, 1'b1, 0, 0};
        jobs[5] = '{1, 2, 2, 32'h0000_0001, 1'b0, 0, 0};

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_busy",     64'(busy), 0);
        chk("rst_done",     64'(done), 0);
        chk("rst_ovf",      64'(ovf), 0);
        chk("rst_c_zero",   64'(c_flat == '0), 1);
        tick();

        for (int v = 0; v < 6; v++) begin
            run_job($sformatf("job%0d", v), jobs[v]);
            tick();
        end

        // Reset during FLUSH discards the partial result.
        rj = '{3, 2, 2, 32'h0, 1'b0, 0, 0};
        fill(rj);
        start = 1'b1;
        k_len = KW'(3);
        tick();
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            drive_beat(b);
            tick();
        end
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        tick();
        tick();
        chk("mid_flush_busy", 64'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  64'(busy), 0);
        chk("mid_rst_c",     64'(c_flat == '0), 1);
        chk("mid_rst_ready", 64'(in_ready), 0);
        extra = 0;
        for (int t = 0; t < 12; t++) begin
            if (done) extra++;
            tick();
        end
        chk("mid_rst_no_done", 64'(extra), 0);
        run_job("post_rst", rj);
        tick();

        // 16-bit accumulator instance: two 255*255 products overflow 2^16.
        start2 = 1'b1;
        k_len2 = KW'(2);
        tick();
        start2 = 1'b0;
        chk("ovf_job_ready", 64'(in_ready2), 1);
        in_valid2 = 1'b1;
        a_vec2    = '1;
        b_vec2    = '1;
        tick();
        tick();
        in_valid2 = 1'b0;
        a_vec2    = '0;
        b_vec2    = '0;
        n = 0;
        while (!done2 && n < BUDGET) begin
            tick();
            n++;
        end
        chk("ovf_job_latency", 64'(n), 64'(2*N-1));
`ifdef SA_SAT_EN
        e2 = 65535;
`else
        e2 = 64514;
`endif
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                chk($sformatf("ovf_job_c%0d%0d", i, c), 64'(cval2(i, c)), e2);
            end
        end
`ifdef SA_SAT_EN
        chk("ovf_flag", 64'(ovf2), 1);
        tick();
        chk("ovf_sticky", 64'(ovf2), 1);
`else
        chk("ovf_flag", 64'(ovf2), 0);
        tick();
        chk("ovf_sticky", 64'(ovf2), 0);
`endif
        start2 = 1'b1;
        k_len2 = '0;
        tick();
        start2 = 1'b0;
        chk("ovf_clear",      64'(ovf2), 0);
        chk("ovf_clear_done", 64'(done2), 1);
        chk("ovf_clear_c",    64'(c_flat2 == '0), 1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
